reset_sequencer: RTL
====================

Name: reset_sequencer

Overview:
- Consumer end of the power-on delayed-reset path. Takes the delayed "release allowed" level and a PLL lock flag, then releases STAGES downstream reset domains one at a time.
- Each stage is released only after the previous stage has acknowledged init-done. Reset is re-asserted on lock loss or when release is withdrawn.
- Sits between the delayed-reset generator/PLL and the ADC-capture, MAC and UDP blocks.

Parameters:
- STAGES, 3: number of sequenced reset outputs (1..8).
- LOCK_FILTER, 8: consecutive synced-lock-high cycles required before the first release (>=1).
- STAGE_GAP, 16: idle cycles between a stage's done and the next stage's release (>=1).
- TIMEOUT, 1024: cycles allowed in WAIT_DONE before FAULT (>=2).
- CW, 16: internal counter width; must hold max(LOCK_FILTER, STAGE_GAP, TIMEOUT).

Ports:
- clk_i, input, 1: single system clock.
- rstn_i, input, 1: asynchronous active-low reset.
- ready_i, input, 1: release-allowed level from the delayed-reset generator; high = delay elapsed; synchronous to clk_i.
- lock_i, input, 1: PLL locked; asynchronous; double-flop synchronized internally to lock_s.
- done_i, input, STAGES: per-stage init-complete acknowledge; synchronous; level.
- rst_o, output, STAGES: per-stage reset; active-high; registered.
- all_ready_o, output, 1: high only in RUN; registered.
- fault_o, output, 1: sticky timeout flag; registered.
- state_o, output, 3: current state encoding, for debug.

Behaviour:
- Async reset (rstn_i low): rst_o = all ones, all_ready_o = 0, fault_o = 0, state = HOLD, lock synchronizer = 0, all counters = 0, stage index idx = 0.
- State encodings: HOLD=0, LOCKWAIT=1, RELEASE=2, WAIT_DONE=3, GAP=4, RUN=5, FAULT=6.
- HOLD: rst_o all ones. ready_i=1 -> LOCKWAIT.
- LOCKWAIT: rst_o all ones. Filter counter increments while lock_s=1 and clears while lock_s=0.
  - lock_s=1 with counter==LOCK_FILTER-1 -> RELEASE, idx=0.
  - First release is therefore LOCK_FILTER cycles after lock_s rises, plus 2 synchronizer cycles after lock_i.
- RELEASE (one cycle): rst_o[idx] <= 0 on the exiting edge; timer cleared; -> WAIT_DONE.
- WAIT_DONE: timer increments each cycle.
  - done_i[idx]=1 and idx==STAGES-1 -> RUN.
  - done_i[idx]=1 and idx<STAGES-1 -> GAP, gap counter cleared.
  - Otherwise timer==TIMEOUT-1 -> FAULT.
  - done and timeout in the same cycle: done wins.
  - done_i bits for other stages are ignored.
- GAP: counts STAGE_GAP cycles; on count==STAGE_GAP-1 -> idx+1, RELEASE.
- RUN: all_ready_o=1. A later drop of done_i has no effect.
- FAULT: rst_o all ones, fault_o=1. Stays in FAULT until ready_i=0, which goes to HOLD and clears fault_o. Lock changes are ignored in FAULT.
- Global abort, in any state except HOLD and FAULT, with priority over every transition above:
  - ready_i=0 -> HOLD.
  - else lock_s=0 in RELEASE, WAIT_DONE, GAP or RUN -> LOCKWAIT.
  - Both aborts: on the next edge rst_o = all ones, all_ready_o = 0, idx = 0, all counters cleared.
- Released stages stay released until an abort or FAULT; at most one bit of rst_o changes 1->0 per edge.
- No combinational input-to-output paths.

Test Plan:
(Parameters for all cases: STAGES=3, LOCK_FILTER=8, STAGE_GAP=4, TIMEOUT=32.)
- Nominal sequence:
  - Stimulus: ready_i=1; lock_i rises at t0; each done_i[k] rises 5 cycles after rst_o[k] falls.
  - Response: rst_o[0] falls at t0+2+8+1. Stages release in order with 4 idle GAP cycles between. all_ready_o=1 one cycle after done_i[2]. state_o trace 0,1,2,3,4,2,3,4,2,3,5.
- Lock glitch:
  - Stimulus: lock_s high for 6 cycles, low for 1, then high.
  - Response: filter restarts; rst_o stays all ones until 8 consecutive high cycles.
- Lock loss in RUN:
  - Stimulus: lock_i deasserted.
  - Response: 3 cycles later rst_o=3'b111, all_ready_o=0, state_o=1. When lock returns, the full sequence repeats from stage 0.
- Timeout:
  - Stimulus: done_i[1] never asserted.
  - Response: 32 cycles after entering WAIT_DONE for stage 1, state_o=6, fault_o=1, rst_o=3'b111. Toggling lock_i has no effect. ready_i=0 returns to HOLD with fault_o=0.
- Simultaneous done and timeout:
  - Stimulus: done_i[0] arrives on timer==31.
  - Response: GAP entered, fault_o stays 0.
- Async reset mid-GAP:
  - Stimulus: rstn_i pulsed low between edges.
  - Response: outputs go to their reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/reset_sequencer_if.sv
// Bundle of the reset sequencer's control and status signals.
// The sequencer itself connects through the slave modport.
interface reset_sequencer_if #(
  parameter int unsigned STAGES = 3
);

  logic              ready_i;
  logic              lock_i;
  logic [STAGES-1:0] done_i;
  logic [STAGES-1:0] rst_o;
  logic              all_ready_o;
  logic              fault_o;
  logic [2:0]        state_o;

  // Sequencer side
  modport slave (
    input  ready_i,
    input  lock_i,
    input  done_i,
    output rst_o,
    output all_ready_o,
    output fault_o,
    output state_o
  );

  // Environment side: reset generator, PLL and downstream blocks
  modport master (
    output ready_i,
    output lock_i,
    output done_i,
    input  rst_o,
    input  all_ready_o,
    input  fault_o,
    input  state_o
  );

endinterface

// File: rtl/reset_sequencer.sv
// Reset sequencer: waits for release-allowed and a filtered PLL lock, then
// releases downstream reset domains one at a time.
// Each stage must acknowledge init-done before the next one is released.
// Losing lock or withdrawing release re-asserts every reset.
module reset_sequencer #(
  parameter int unsigned STAGES      = 3,
  parameter int unsigned LOCK_FILTER = 8,
  parameter int unsigned STAGE_GAP   = 16,
  parameter int unsigned TIMEOUT     = 1024,
  parameter int unsigned CW          = 16
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  reset_sequencer_if.slave sq_if
);

  localparam int unsigned IW = (STAGES > 1) ? $clog2(STAGES) : 1;

  localparam logic [2:0] S_HOLD      = 3'd0;
  localparam logic [2:0] S_LOCKWAIT  = 3'd1;
  localparam logic [2:0] S_RELEASE   = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_GAP       = 3'd4;
  localparam logic [2:0] S_RUN       = 3'd5;
  localparam logic [2:0] S_FAULT     = 3'd6;

  localparam logic [CW-1:0] LF_LAST  = CW'(LOCK_FILTER - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(STAGE_GAP - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(STAGES - 1);

  // Elaboration-time parameter sanity
  if (STAGES < 1 || STAGES > 8) begin : g_bad_stages
    $error("reset_sequencer: STAGES must be 1..8");
  end
  if (LOCK_FILTER < 1) begin : g_bad_filter
    $error("reset_sequencer: LOCK_FILTER must be >= 1");
  end
  if (STAGE_GAP < 1) begin : g_bad_gap
    $error("reset_sequencer: STAGE_GAP must be >= 1");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("reset_sequencer: TIMEOUT must be >= 2");
  end
  if ((CW < 32) && ((LOCK_FILTER >= (32'd1 << CW)) || (STAGE_GAP >= (32'd1 << CW)) ||
                    (TIMEOUT >= (32'd1 << CW)))) begin : g_bad_cw
    $error("reset_sequencer: CW too narrow for the configured counts");
  end
  if ($bits(sq_if.done_i) != STAGES) begin : g_bad_if
    $error("reset_sequencer: interface STAGES does not match module STAGES");
  end

  logic              lock_meta_q;
  logic              lock_s_q;

  logic [2:0]        state_q,     state_d;
  logic [IW-1:0]     idx_q,       idx_d;
  logic [CW-1:0]     cnt_q,       cnt_d;
  logic [STAGES-1:0] rst_q,       rst_d;
  logic              all_ready_q, all_ready_d;
  logic              fault_q,     fault_d;

  // Two-flop synchronizer for the asynchronous PLL lock flag
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      lock_meta_q <= sq_if.lock_i;
      lock_s_q    <= lock_meta_q;
    end
  end

  // State, stage index, shared counter and registered outputs
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= S_HOLD;
      idx_q       <= '0;
      cnt_q       <= '0;
      rst_q       <= '1;
      all_ready_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      rst_q       <= rst_d;
      all_ready_q <= all_ready_d;
      fault_q     <= fault_d;
    end
  end

  // Next-state and next-output logic; one counter serves as lock filter,
  // done timer and gap timer since only one is live in any state
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    rst_d   = rst_q;

    case (state_q)
      S_HOLD: begin
        rst_d = '1;
        if (sq_if.ready_i) begin
          state_d = S_LOCKWAIT;
          cnt_d   = '0;
        end
      end

      S_LOCKWAIT: begin
        rst_d = '1;
        if (lock_s_q) begin
          if (cnt_q == LF_LAST) begin
            state_d = S_RELEASE;
            idx_d   = '0;
            cnt_d   = '0;
          end else begin
            cnt_d = CW'(cnt_q + 1'b1);
          end
        end else begin
          cnt_d = '0;
        end
      end

      S_RELEASE: begin
        rst_d[idx_q] = 1'b0;
        cnt_d        = '0;
        state_d      = S_WAIT_DONE;
      end

      S_WAIT_DONE: begin
        cnt_d = CW'(cnt_q + 1'b1);
        // Done beats a simultaneous timeout
        if (sq_if.done_i[idx_q]) begin
          cnt_d   = '0;
          state_d = (idx_q == IDX_LAST) ? S_RUN : S_GAP;
        end else if (cnt_q == TO_LAST) begin
          state_d = S_FAULT;
          rst_d   = '1;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end

      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_RELEASE;
          idx_d   = IW'(idx_q + 1'b1);
          cnt_d   = '0;
        end else begin
          cnt_d = CW'(cnt_q + 1'b1);
        end
      end

      S_RUN: begin
        // Terminal until an abort; later done_i drops are ignored
      end

      S_FAULT: begin
        rst_d = '1;
        if (!sq_if.ready_i) begin
          state_d = S_HOLD;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = S_HOLD;
        rst_d   = '1;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase

    // Aborts override every transition above; FAULT only exits via ready_i
    if (state_q != S_HOLD && state_q != S_FAULT) begin
      if (!sq_if.ready_i) begin
        state_d = S_HOLD;
        rst_d   = '1;
        idx_d   = '0;
        cnt_d   = '0;
      end else if (!lock_s_q && state_q != S_LOCKWAIT) begin
        state_d = S_LOCKWAIT;
        rst_d   = '1;
        idx_d   = '0;
        cnt_d   = '0;
      end
    end

    all_ready_d = (state_d == S_RUN);
    fault_d     = (state_d == S_FAULT);
  end

  assign sq_if.rst_o       = rst_q;
  assign sq_if.all_ready_o = all_ready_q;
  assign sq_if.fault_o     = fault_q;
  assign sq_if.state_o     = state_q;

endmodule
